// File: rtl/div_iter.sv
// div_iter: iterative restoring radix-2 divider with valid/ready handshakes.
// One quotient bit per BUSY cycle, MSB first. Latency is a_bits cycles for
// every operand pair, including divide-by-zero.
// Optional feature: define DIV_ITER_SIGNED_EN to add the i_signed input for
// two's-complement operation. Without it the block is unsigned only.
//
// state  | meaning
// IDLE   | waiting for a request, o_ready high
// BUSY   | resolving quotient bits, a_bits cycles
// DONE   | result held on outputs until i_ready
module div_iter #(
  parameter int a_bits = 32,
  parameter int b_bits = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [a_bits-1:0] i_a,
  input  logic [b_bits-1:0] i_b,
`ifdef DIV_ITER_SIGNED_EN
  input  logic              i_signed,
`endif
  output logic              o_valid,
  input  logic              i_ready,
  output logic [a_bits-1:0] o_q,
  output logic [b_bits-1:0] o_r,
  output logic              o_dbz
);

  localparam int CW = $clog2(a_bits);
  localparam logic [CW-1:0] CNT_LAST = CW'(a_bits - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        r_state;
  logic [CW-1:0]     r_cnt;
  logic [a_bits-1:0] r_q;     // dividend shifting out, quotient shifting in
  logic [b_bits-1:0] r_rem;   // partial remainder, always < divisor
  logic [b_bits-1:0] r_b;     // divisor magnitude
  logic [b_bits-1:0] r_a_lo;  // raw dividend low bits for divide-by-zero
  logic              r_dbz;

  logic              w_accept;
  logic              w_last;
  logic [b_bits:0]   w_shift;
  logic              w_ge;
  logic [b_bits-1:0] w_diff;
  logic [a_bits-1:0] w_q_nxt;
  logic [b_bits-1:0] w_rem_nxt;
  logic [a_bits-1:0] w_a_mag;
  logic [b_bits-1:0] w_b_mag;
  logic [a_bits-1:0] w_q_fin;
  logic [b_bits-1:0] w_r_fin;

  assign w_accept = i_valid && (r_state == S_IDLE);
  assign w_last   = (r_state == S_BUSY) && (r_cnt == '0);

  // One restoring step: shift in next dividend bit, subtract if it fits.
  assign w_shift   = {r_rem, r_q[a_bits-1]};
  assign w_ge      = (w_shift >= {1'b0, r_b});
  assign w_diff    = w_shift[b_bits-1:0] - r_b;
  assign w_rem_nxt = w_ge ? w_diff : w_shift[b_bits-1:0];
  assign w_q_nxt   = {r_q[a_bits-2:0], w_ge};

`ifdef DIV_ITER_SIGNED_EN
  logic r_neg_q;
  logic r_neg_r;

  // Divide magnitudes; the most-negative dividend negates to itself, which is
  // still the correct unsigned magnitude, so most-negative / -1 falls out.
  assign w_a_mag = (i_signed && i_a[a_bits-1]) ? -i_a : i_a;
  assign w_b_mag = (i_signed && i_b[b_bits-1]) ? -i_b : i_b;
  assign w_q_fin = r_neg_q ? -w_q_nxt : w_q_nxt;
  assign w_r_fin = r_neg_r ? -w_rem_nxt : w_rem_nxt;

  // Result signs: quotient negative on sign mismatch, remainder follows dividend.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (w_accept) begin
      r_neg_q <= i_signed && (i_a[a_bits-1] ^ i_b[b_bits-1]);
      r_neg_r <= i_signed && i_a[a_bits-1];
    end
  end
`else
  assign w_a_mag = i_a;
  assign w_b_mag = i_b;
  assign w_q_fin = w_q_nxt;
  assign w_r_fin = w_rem_nxt;
`endif

  // Control: state and down-counter of remaining BUSY cycles.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state <= S_BUSY;
            r_cnt   <= CNT_LAST;
          end
        end
        S_BUSY: begin
          if (r_cnt == '0) r_state <= S_DONE;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        S_DONE: begin
          if (i_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Datapath: capture operands, iterate, and fix up the result on the last step.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q    <= '0;
      r_rem  <= '0;
      r_b    <= '0;
      r_a_lo <= '0;
      r_dbz  <= 1'b0;
    end else if (w_accept) begin
      r_q    <= w_a_mag;
      r_rem  <= '0;
      r_b    <= w_b_mag;
      r_a_lo <= i_a[b_bits-1:0];
      r_dbz  <= (i_b == '0);
    end else if (w_last) begin
      r_q   <= r_dbz ? '1     : w_q_fin;
      r_rem <= r_dbz ? r_a_lo : w_r_fin;
    end else if (r_state == S_BUSY) begin
      r_q   <= w_q_nxt;
      r_rem <= w_rem_nxt;
    end
  end

  assign o_ready = (r_state == S_IDLE);
  assign o_valid = (r_state == S_DONE);
  assign o_q     = o_valid ? r_q   : '0;
  assign o_r     = o_valid ? r_rem : '0;
  assign o_dbz   = o_valid && r_dbz;

endmodule

// File: tb/tb_div_iter.sv
// Testbench for div_iter at default widths (32/32). Signed cases run only when
// DIV_ITER_SIGNED_EN is defined for both files.
module tb_div_iter;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        i_ready = 1'b0;
  logic [31:0] i_a = '0;
  logic [31:0] i_b = '0;
`ifdef DIV_ITER_SIGNED_EN
  logic        i_signed = 1'b0;
`endif
  logic        o_ready;
  logic        o_valid;
  logic [31:0] o_q;
  logic [31:0] o_r;
  logic        o_dbz;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
  } vec_t;

  vec_t tv[10];

  div_iter #(.a_bits(32), .b_bits(32)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_a     (i_a),
    .i_b     (i_b),
`ifdef DIV_ITER_SIGNED_EN
    .i_signed(i_signed),
`endif
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_q     (o_q),
    .o_r     (o_r),
    .o_dbz   (o_dbz)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic dbz);
    longint sa;
    longint sb;
    dbz = (b == 32'd0);
    if (dbz) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!s) begin
      q = a / b;
      r = a % b;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end
  endfunction

  // Issue one request, check latency and result, hold off i_ready for 'hold'
  // cycles, then consume and check the return to IDLE.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er, input logic edbz,
                        input int hold, input string nm);
    int n;
    int lat;
    n = 0;
    while (!o_ready && n < 100) begin
      @(posedge i_clk); #1;
      n++;
    end
    chk({nm, " ready"}, o_ready, 1'b1);
    i_valid = 1'b1;
    i_a = a;
    i_b = b;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    i_a = $urandom;
    i_b = $urandom;
    lat = 0;
    while (!o_valid && lat < 100) begin
      if (lat == 3) chk({nm, " busy outputs"}, {o_ready, o_dbz, o_r, o_q}, '0);
      @(posedge i_clk); #1;
      lat++;
    end
    chk({nm, " latency"}, lat, 32);
    chk({nm, " q"}, o_q, eq);
    chk({nm, " r"}, o_r, er);
    chk({nm, " dbz"}, o_dbz, edbz);
    for (int h = 0; h < hold; h++) begin
      @(posedge i_clk); #1;
      chk({nm, " hold"}, {o_valid, o_ready, o_dbz, o_r, o_q}, {1'b1, 1'b0, edbz, er, eq});
    end
    i_ready = 1'b1;
    @(posedge i_clk); #1;
    i_ready = 1'b0;
    chk({nm, " consumed"}, {o_valid, o_ready, o_dbz, o_r, o_q}, {1'b0, 1'b1, 1'b0, 64'd0});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] ra, rb, eq, er;
    logic        ed, rs;
    logic [31:0] bq[2];
    logic [31:0] br[2];
    int          bn[2];
    int          got, n;

    tv[0] = '{32'd100,        32'd7,          32'd14,         32'd2,        1'b0};
    tv[1] = '{32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678, 1'b1};
    tv[2] = '{32'd9,          32'd3,          32'd3,          32'd0,        1'b0};
    tv[3] = '{32'd0,          32'd5,          32'd0,          32'd0,        1'b0};
    tv[4] = '{32'd5,          32'd10,         32'd0,          32'd5,        1'b0};
    tv[5] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,        1'b0};
    tv[6] = '{32'd7,          32'd7,          32'd1,          32'd0,        1'b0};
    tv[7] = '{32'd1,          32'd0,          32'hFFFF_FFFF,  32'd1,        1'b1};
    tv[8] = '{32'hFFFF_FFFF,  32'd2,          32'h7FFF_FFFF,  32'd1,        1'b0};
    tv[9] = '{32'd1000000,    32'h0001_0000,  32'd15,         32'd16960,    1'b0};

    // Reset state, observed before any clock edge.
    #2;
    chk("reset outputs", {o_valid, o_dbz, o_r, o_q}, '0);
    chk("reset ready", o_ready, 1'b1);
    #1;
    i_rst_n = 1'b1;

    // Directed table; first entry is accepted on the first edge after reset.
    for (int k = 0; k < 10; k++) run_op(tv[k].a, tv[k].b, tv[k].q, tv[k].r, tv[k].dbz, 0, $sformatf("vec%0d", k));

    // Backpressure: result held for 10 cycles with i_ready low.
    run_op(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 10, "backpressure");

    // Back-to-back: i_valid and i_ready held high, second request waits for IDLE.
    i_ready = 1'b1;
    i_valid = 1'b1;
    i_a = 32'hFFFF_FFFF;
    i_b = 32'd1;
    @(posedge i_clk); #1;
    i_a = 32'd5;
    i_b = 32'd10;
    got = 0;
    n = 0;
    while (got < 2 && n < 200) begin
      @(posedge i_clk); #1;
      n++;
      if (o_valid) begin
        bq[got] = o_q;
        br[got] = o_r;
        bn[got] = n;
        got++;
      end
    end
    i_valid = 1'b0;
    @(posedge i_clk); #1;
    i_ready = 1'b0;
    chk("b2b count", got, 2);
    if (got == 2) begin
      chk("b2b q0", bq[0], 32'hFFFF_FFFF);
      chk("b2b r0", br[0], 32'd0);
      chk("b2b q1", bq[1], 32'd0);
      chk("b2b r1", br[1], 32'd5);
      chk("b2b t0", bn[0], 32);
      chk("b2b t1", bn[1], 66);
    end
    chk("b2b idle", {o_valid, o_ready}, 2'b01);

    // Reset 5 cycles into an operation; the aborted op must never produce a result.
    i_valid = 1'b1;
    i_a = 32'd100;
    i_b = 32'd7;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    repeat (5) @(posedge i_clk);
    #1;
    i_rst_n = 1'b0;
    #1;
    chk("abort outputs", {o_valid, o_dbz, o_r, o_q}, '0);
    chk("abort ready", o_ready, 1'b1);
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    run_op(32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 0, "after abort");

`ifdef DIV_ITER_SIGNED_EN
    i_signed = 1'b1;
    run_op(32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 0, "signed -7/2");
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 0, "signed min/-1");
    run_op(32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1, 0, "signed dbz");
    run_op(32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 0, "signed 7/-2");
    i_signed = 1'b0;
`endif

    // Random operands against the arithmetic reference.
    for (int k = 0; k < 40; k++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = $urandom >> $urandom_range(0, 31);
        default: rb = $urandom;
      endcase
      rs = 1'b0;
`ifdef DIV_ITER_SIGNED_EN
      rs = 1'($urandom_range(0, 1));
      i_signed = rs;
`endif
      ref_div(ra, rb, rs, eq, er, ed);
      run_op(ra, rb, eq, er, ed, k % 3, $sformatf("rand%0d", k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/div_iter.md
DIV_ITER -- requirements
Module: div_iter

Interface
REQ-001 SHALL have parameter a_bits, default 32, dividend and quotient width (>=2).
REQ-002 SHALL have parameter b_bits, default 32, divisor and remainder width (>=2, <=a_bits).
REQ-003 SHALL have port i_clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port i_valid  input  1  request valid.
REQ-006 SHALL have port o_ready  output  1  block can accept a request.
REQ-007 SHALL have port i_a  input  a_bits  dividend.
REQ-008 SHALL have port i_b  input  b_bits  divisor.
REQ-009 SHALL have port o_valid  output  1  result valid.
REQ-010 SHALL have port i_ready  input  1  consumer accepts result.
REQ-011 SHALL have port o_q  output  a_bits  quotient.
REQ-012 SHALL have port o_r  output  b_bits  remainder.
REQ-013 SHALL have port o_dbz  output  1  divide-by-zero flag, qualified by o_valid.

Function
REQ-014 SHALL implement a restoring radix-2 divider with states IDLE, BUSY and DONE, resolving one quotient bit per BUSY cycle, MSB first.
REQ-015 SHALL assert o_ready only in IDLE; a request is accepted on an edge where i_valid and o_ready are both high, and i_a/i_b are captured on that edge.
REQ-016 SHALL transition IDLE->BUSY on acceptance, and stay in BUSY for exactly a_bits edges, counted by a bit counter.
REQ-017 SHALL transition BUSY->DONE on the a_bits-th BUSY edge, so o_valid rises exactly a_bits cycles after the accepting edge, independent of operand values.
REQ-018 SHALL hold o_valid, o_q, o_r and o_dbz stable in DONE until an edge with i_ready high, then return to IDLE.
REQ-019 SHALL NOT accept a new request on the same edge a result is consumed; o_ready rises the cycle after DONE->IDLE.
REQ-020 SHALL produce o_q = floor(i_a / i_b) and o_r = i_a mod i_b for unsigned operands, with o_r < i_b always.
REQ-021 SHALL, when i_b = 0, still take the full latency and give o_q = all ones, o_r = i_a[b_bits-1:0] and o_dbz = 1; otherwise o_dbz = 0.
REQ-022 SHALL ignore i_a, i_b and i_valid while in BUSY or DONE.
REQ-023 SHALL drive o_q, o_r and o_dbz to zero when not in DONE.

Reset
REQ-024 SHALL, on i_rst_n low, asynchronously force state IDLE, counter 0, o_valid 0, o_q 0, o_r 0 and o_dbz 0; o_ready SHALL be 1 while in IDLE after reset.
REQ-025 SHALL abort any in-flight operation when reset is asserted in BUSY or DONE, and produce no result for it.
REQ-026 SHALL accept a request on the first rising edge after i_rst_n deasserts.

Configuration
REQ-027 SHALL, with macro DIV_ITER_SIGNED_EN defined, add input port i_signed (1 bit, captured with i_a/i_b).
REQ-028 SHALL, when i_signed is high, treat operands as two's complement: quotient truncates toward zero, remainder takes the dividend's sign, and the latency is unchanged.
REQ-029 SHALL, with i_signed high, return o_q = most-negative value and o_r = 0 for most-negative / -1; divide-by-zero SHALL return o_q = all ones, o_r = i_a[b_bits-1:0] and o_dbz = 1.
REQ-030 SHALL, without DIV_ITER_SIGNED_EN, omit i_signed and its logic and be unsigned only.

Verification
REQ-031 SHALL cover the basic case (defaults): i_a=100, i_b=7 accepted -> o_valid exactly 32 cycles later, o_q=14, o_r=2, o_dbz=0.
REQ-032 SHALL cover divide-by-zero: i_a=0x12345678, i_b=0 -> after 32 cycles o_q=0xFFFFFFFF, o_r=0x12345678, o_dbz=1.
REQ-033 SHALL cover backpressure: i_ready held low for 10 cycles after o_valid -> outputs stable and o_ready low throughout; o_ready rises the cycle after the consuming edge.
REQ-034 SHALL cover reset mid-operation: i_rst_n pulsed low 5 cycles after acceptance -> o_valid never asserts for it; a next request of 9/3 yields o_q=3, o_r=0.
REQ-035 SHALL cover back-to-back requests: i_valid held high with 0xFFFFFFFF/1 then 5/10 -> o_q=0xFFFFFFFF, o_r=0, then o_q=0, o_r=5, in order with no lost request.
REQ-036 SHALL cover signed operation with DIV_ITER_SIGNED_EN and i_signed=1: -7/2 -> o_q=-3, o_r=-1; 0x80000000/-1 -> o_q=0x80000000, o_r=0.
